// File: rtl/fir_xifu_id_queue.sv
// fir_xifu_id_queue: XIF issue decode plus DEPTH-entry in-order queue toward the FIR EX stage.
// Define FIR_XIFU_ID_QUEUE_BYPASS_EN to forward an issue straight to EX when the queue is empty.
module fir_xifu_id_queue #(
   parameter int XLEN     = 32,
   parameter int ID_WIDTH = 4,
   parameter int DEPTH    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       issue_valid_i,
   output logic                       issue_ready_o,
   input  logic [31:0]                issue_instr_i,
   input  logic [XLEN-1:0]            issue_rs0_i,
   input  logic [ID_WIDTH-1:0]        issue_id_i,
   output logic                       issue_accept_o,
   output logic                       issue_writeback_o,
   output logic                       issue_loadstore_o,
   input  logic                       commit_valid_i,
   input  logic [ID_WIDTH-1:0]        commit_id_i,
   input  logic                       commit_kill_i,
   output logic                       ex_valid_o,
   input  logic                       ex_ready_i,
   output logic [1:0]                 ex_instr_o,
   output logic [XLEN-1:0]            ex_base_o,
   output logic [XLEN-1:0]            ex_offset_o,
   output logic [4:0]                 ex_rs1_o,
   output logic [4:0]                 ex_rs2_o,
   output logic [4:0]                 ex_rd_o,
   output logic [ID_WIDTH-1:0]        ex_id_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [6:0] INSTR_OPCODE = 7'b0001011;
   localparam logic [2:0] F3_XFIRLW   = 3'b000;
   localparam logic [2:0] F3_XFIRSW   = 3'b001;
   localparam logic [2:0] F3_XFIRDOTP = 3'b010;
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {INSTR_INVALID, INSTR_XFIRLW, INSTR_XFIRSW, INSTR_XFIRDOTP} fir_xifu_instr_t;

   typedef struct packed {
      fir_xifu_instr_t     instr;
      logic [XLEN-1:0]     base;
      logic [XLEN-1:0]     offset;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [ID_WIDTH-1:0] id;
      logic                killed;
   } entry_t;

   entry_t          q [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   fir_xifu_instr_t dec;
   logic [11:0]     imm;
   entry_t          new_e, head, out;
   logic            kill, empty, push, push_q, pop_q, q_valid;

   assign kill = commit_valid_i & commit_kill_i;
   assign dec  = !(issue_valid_i && issue_instr_i[6:0] == INSTR_OPCODE) ? INSTR_INVALID :
                 issue_instr_i[14:12] == F3_XFIRLW   ? INSTR_XFIRLW :
                 issue_instr_i[14:12] == F3_XFIRSW   ? INSTR_XFIRSW :
                 issue_instr_i[14:12] == F3_XFIRDOTP ? INSTR_XFIRDOTP : INSTR_INVALID;
   assign imm  = dec == INSTR_XFIRSW ? {issue_instr_i[31:25], issue_instr_i[11:7]} : issue_instr_i[31:20];

   assign issue_accept_o    = dec != INSTR_INVALID;
   assign issue_writeback_o = issue_accept_o && dec != INSTR_XFIRDOTP;
   assign issue_loadstore_o = issue_writeback_o;
   assign issue_ready_o     = count != FULL_CNT;

   assign new_e.instr  = dec;
   assign new_e.base   = issue_rs0_i;
   assign new_e.offset = {{(XLEN-12){imm[11]}}, imm};
   assign new_e.rs1    = issue_instr_i[19:15];
   assign new_e.rs2    = issue_instr_i[24:20];
   assign new_e.rd     = issue_instr_i[11:7];
   assign new_e.id     = issue_id_i;
   assign new_e.killed = kill && commit_id_i == issue_id_i;

   assign empty   = count == '0;
   assign head    = q[rd_ptr];
   assign push    = issue_valid_i & issue_ready_o & issue_accept_o;
   assign q_valid = !empty & !head.killed;
   // A killed head drains in one cycle whether or not EX is ready.
   assign pop_q   = !empty & (head.killed | ex_ready_i);

`ifdef FIR_XIFU_ID_QUEUE_BYPASS_EN
   logic byp;
   assign byp        = empty & push;
   assign out        = byp ? new_e : empty ? '0 : head;
   assign ex_valid_o = byp ? !new_e.killed : q_valid;
   assign push_q     = push & !(byp & ex_ready_i & !new_e.killed);
`else
   assign out        = empty ? '0 : head;
   assign ex_valid_o = q_valid;
   assign push_q     = push;
`endif

   assign ex_instr_o  = out.instr;
   assign ex_base_o   = out.base;
   assign ex_offset_o = out.offset;
   assign ex_rs1_o    = out.rs1;
   assign ex_rs2_o    = out.rs2;
   assign ex_rd_o     = out.rd;
   assign ex_id_o     = out.id;
   assign count_o     = count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
         for (int i = 0; i < DEPTH; i++) q[i].killed <= 1'b0;
      end else begin
         if (kill)
            for (int i = 0; i < DEPTH; i++)
               if (vld[i] && q[i].id == commit_id_i) q[i].killed <= 1'b1;
         if (pop_q) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         if (push_q) begin
            q[wr_ptr]   <= new_e;
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         count <= count + (AW+1)'(push_q) - (AW+1)'(pop_q);
      end
   end
endmodule

// File: tb/tb_fir_xifu_id_queue.sv
// tb_fir_xifu_id_queue: directed checks of decode, ordering, kill and clear for fir_xifu_id_queue.
module tb_fir_xifu_id_queue;
   logic        clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
   logic        issue_valid_i = 1'b0, issue_ready_o;
   logic [31:0] issue_instr_i = '0, issue_rs0_i = '0;
   logic [3:0]  issue_id_i = '0, commit_id_i = '0, ex_id_o;
   logic        issue_accept_o, issue_writeback_o, issue_loadstore_o;
   logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
   logic        ex_valid_o, ex_ready_i = 1'b0;
   logic [1:0]  ex_instr_o;
   logic [31:0] ex_base_o, ex_offset_o;
   logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic [2:0]  count_o;
   int          n_chk = 0, n_err = 0;

   fir_xifu_id_queue #(.XLEN(32), .ID_WIDTH(4), .DEPTH(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
      .issue_rs0_i(issue_rs0_i), .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o),
      .issue_writeback_o(issue_writeback_o), .issue_loadstore_o(issue_loadstore_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_instr_o(ex_instr_o),
      .ex_base_o(ex_base_o), .ex_offset_o(ex_offset_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
      .ex_rd_o(ex_rd_o), .ex_id_o(ex_id_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, f3, rd, 7'b0001011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0001011};
   endfunction

   initial begin
      #2;
      chk("rst_count", count_o, 0);
      chk("rst_exv", ex_valid_o, 0);
      chk("rst_ready", issue_ready_o, 1);
      chk("rst_instr", ex_instr_o, 0);
      #10 rst_ni = 1'b1;
      tick();
      // single XFIRLW
      issue_valid_i = 1; issue_instr_i = enc_i(3'b000, 5'd7, 5'd5, 12'hFFC);
      issue_rs0_i = 32'h1000; issue_id_i = 3; ex_ready_i = 1;
      #4;
      chk("lw_acc", issue_accept_o, 1);
      chk("lw_wb", issue_writeback_o, 1);
      chk("lw_ls", issue_loadstore_o, 1);
`ifdef FIR_XIFU_ID_QUEUE_BYPASS_EN
      chk("lw_byp_exv", ex_valid_o, 1);
      chk("lw_byp_off", ex_offset_o, 32'hFFFFFFFC);
      tick();
      issue_valid_i = 0;
      #4;
      chk("lw_byp_cnt", count_o, 0);
`else
      chk("lw_exv0", ex_valid_o, 0);
      tick();
      issue_valid_i = 0;
      #4;
      chk("lw_exv", ex_valid_o, 1);
      chk("lw_off", ex_offset_o, 32'hFFFFFFFC);
      chk("lw_base", ex_base_o, 32'h1000);
      chk("lw_id", ex_id_o, 3);
      chk("lw_rd", ex_rd_o, 7);
      chk("lw_rs1", ex_rs1_o, 5);
      chk("lw_instr", ex_instr_o, 1);
      chk("lw_cnt", count_o, 1);
      tick();
      #4;
      chk("lw_drained", count_o, 0);
      chk("lw_exv_after", ex_valid_o, 0);
`endif
      // unknown funct3, then XFIRDOTP
      tick();
      issue_valid_i = 1; issue_instr_i = enc_i(3'b111, 5'd1, 5'd2, 12'h0); issue_id_i = 4;
      #4;
      chk("bad_acc", issue_accept_o, 0);
      chk("bad_wb", issue_writeback_o, 0);
      tick();
      issue_instr_i = {7'b0, 5'd3, 5'd2, 3'b010, 5'd1, 7'b0001011}; issue_id_i = 5;
      #4;
      chk("bad_cnt", count_o, 0);
      chk("dotp_acc", issue_accept_o, 1);
      chk("dotp_wb", issue_writeback_o, 0);
      chk("dotp_ls", issue_loadstore_o, 0);
`ifndef FIR_XIFU_ID_QUEUE_BYPASS_EN
      tick();
      issue_valid_i = 0;
      #4;
`endif
      chk("dotp_exv", ex_valid_o, 1);
      chk("dotp_instr", ex_instr_o, 3);
      chk("dotp_id", ex_id_o, 5);
      chk("dotp_rs2", ex_rs2_o, 3);
      tick();
      issue_valid_i = 0;
      #4;
      chk("dotp_cnt", count_o, 0);
      chk("invalid_idle", issue_accept_o, 0);
      // fill to DEPTH, then drain in order
      ex_ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         issue_valid_i = 1; issue_instr_i = enc_i(3'b000, 5'd1, 5'd1, 12'(i)); issue_id_i = 4'(i);
      end
      tick();
      issue_valid_i = 0;
      #4;
      chk("full_cnt", count_o, 4);
      chk("full_ready", issue_ready_o, 0);
      tick();
      ex_ready_i = 1;
      for (int k = 0; k < 4; k++) begin
         #4;
         chk("drain_exv", ex_valid_o, 1);
         chk("drain_id", ex_id_o, k);
         chk("drain_off", ex_offset_o, k);
         chk("drain_ready", issue_ready_o, k != 0);
         tick();
      end
      #4;
      chk("drain_cnt", count_o, 0);
      // kill the middle of three
      tick();
      ex_ready_i = 0;
      for (int i = 1; i < 4; i++) begin
         issue_valid_i = 1; issue_instr_i = enc_i(3'b000, 5'd2, 5'd2, 12'h0); issue_id_i = 4'(i);
         tick();
      end
      issue_valid_i = 0; commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 2;
      tick();
      commit_valid_i = 0; commit_kill_i = 0; ex_ready_i = 1;
      #4;
      chk("kill_cnt", count_o, 3);
      chk("kill_exv1", ex_valid_o, 1);
      chk("kill_id1", ex_id_o, 1);
      tick();
      #4;
      chk("kill_bubble", ex_valid_o, 0);
      chk("kill_bub_id", ex_id_o, 2);
      tick();
      #4;
      chk("kill_exv3", ex_valid_o, 1);
      chk("kill_id3", ex_id_o, 3);
      tick();
      #4;
      chk("kill_cnt_end", count_o, 0);
      // clear beats push, pop and kill
      tick();
      ex_ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         issue_valid_i = 1; issue_instr_i = enc_i(3'b000, 5'd3, 5'd3, 12'h0); issue_id_i = 4'(i + 8);
         tick();
      end
      ex_ready_i = 1; commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 8; clear_i = 1;
      #4;
      chk("clr_pre_cnt", count_o, 4);
      tick();
      issue_valid_i = 0; ex_ready_i = 0; commit_valid_i = 0; commit_kill_i = 0; clear_i = 0;
      #4;
      chk("clr_cnt", count_o, 0);
      chk("clr_exv", ex_valid_o, 0);
      chk("clr_ready", issue_ready_o, 1);
`ifdef FIR_XIFU_ID_QUEUE_BYPASS_EN
      tick();
      ex_ready_i = 1; issue_valid_i = 1; issue_instr_i = enc_s(5'd9, 5'd4, 12'hFEC); issue_id_i = 6;
      #4;
      chk("byp_exv", ex_valid_o, 1);
      chk("byp_off", ex_offset_o, 32'hFFFFFFEC);
      chk("byp_instr", ex_instr_o, 2);
      chk("byp_rs2", ex_rs2_o, 9);
      tick();
      issue_valid_i = 0;
      #4;
      chk("byp_cnt", count_o, 0);
      chk("byp_exv_after", ex_valid_o, 0);
`else
      tick();
      ex_ready_i = 0; issue_valid_i = 1; issue_instr_i = enc_s(5'd9, 5'd4, 12'hFEC); issue_id_i = 6;
      tick();
      issue_valid_i = 0;
      #4;
      chk("sw_off", ex_offset_o, 32'hFFFFFFEC);
      chk("sw_instr", ex_instr_o, 2);
      chk("sw_rs2", ex_rs2_o, 9);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
